bnn_infer_ctrl: RTL and testbench
=================================

BNN_INFER_CTRL -- requirements
Module: bnn_infer_ctrl

Interface
REQ-001 SHALL have parameter IMG_W, default 30, image width in pixels.
REQ-002 SHALL have parameter IMG_H, default 30, image height in pixels.
REQ-003 SHALL have parameter PAD_BITS, default 4, LSB padding bits stripped from the input bus.
REQ-004 SHALL have parameter RESULT_W, default 4, class index width.
REQ-005 SHALL have parameter NUM_CLASSES, default 10, count of legal class indices.
REQ-006 SHALL have parameter TIMEOUT_CYC, default 4096, maximum RUN cycles before error.
REQ-007 SHALL have port clk, input, 1, clock.
REQ-008 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port img_in, input, IMG_W*IMG_H+PAD_BITS, image with padding in LSBs.
REQ-010 SHALL have port img_valid, input, 1, image offered.
REQ-011 SHALL have port img_ready, output, 1, controller accepts an image.
REQ-012 SHALL have port core_img, output, IMG_W*IMG_H, latched image to the BNN core.
REQ-013 SHALL have port core_start, output, 1, one-cycle start pulse to the core.
REQ-014 SHALL have port core_done, input, 1, core result-valid pulse.
REQ-015 SHALL have port core_result, input, RESULT_W, core class index.
REQ-016 SHALL have port result_out, output, RESULT_W, held class result.
REQ-017 SHALL have port result_valid, output, 1, result_out is valid.
REQ-018 SHALL have port result_clear, input, 1, consumer acknowledge/clear.
REQ-019 SHALL have port err, output, 1, timeout or out-of-range result.
REQ-020 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-021 SHALL have port lat_cycles, output, 16, cycles from core_start to core_done.

Function
REQ-022 SHALL implement FSM states IDLE, START, RUN, DONE, ERR.
REQ-023 IDLE: img_ready=1; img_valid && img_ready SHALL latch img_in[MSB:PAD_BITS] into core_img and go to START.
REQ-024 START: core_start=1 for exactly one cycle, then RUN; core_img SHALL stay stable from START until the next IDLE acceptance.
REQ-025 RUN: core_done SHALL capture core_result into result_out; next state DONE if core_result < NUM_CLASSES, else ERR.
REQ-026 RUN: watchdog SHALL count RUN cycles; the cycle it reaches TIMEOUT_CYC-1 without core_done SHALL go to ERR.
REQ-027 core_done on the watchdog terminal cycle SHALL win (DONE/ERR by range check, not timeout).
REQ-028 DONE: result_valid=1 and result_out held until result_clear, then IDLE.
REQ-029 ERR: err=1, result_valid=0 until result_clear, then IDLE; err SHALL clear on that transition.
REQ-030 img_ready SHALL be 0 outside IDLE; img_valid outside IDLE SHALL be ignored.
REQ-031 core_done outside RUN and result_clear outside DONE/ERR SHALL be ignored.
REQ-032 Latency: result_valid SHALL assert on the cycle after core_done is sampled.
REQ-033 Watchdog width SHALL be $clog2(TIMEOUT_CYC); it SHALL be zeroed on entry to RUN.

Reset
REQ-034 rst_n low SHALL asynchronously force IDLE; img_ready=1; core_start, result_valid, err=0; result_out, core_img, lat_cycles=0, watchdog=0.
REQ-035 Reset mid-RUN SHALL abandon the inference; a later core_done SHALL be ignored.

Configuration
REQ-036 With BNN_INFER_PERF_EN defined, lat_cycles SHALL count RUN cycles (saturating at 16'hFFFF) and update on core_done; it SHALL hold until the next START.
REQ-037 Without BNN_INFER_PERF_EN, lat_cycles SHALL be tied to 0 and no counter logic SHALL be synthesised.

Structure
REQ-038 Package bnn_pkg SHALL hold the state enum bnn_ctrl_state_t and default IMG_W/IMG_H/RESULT_W/NUM_CLASSES constants.
REQ-039 Watchdog SHALL be sub-module bnn_watchdog (params TIMEOUT_CYC; ports clk, rst_n, clear, enable, expired).

Verification
REQ-040 Image with pixel bits 0xA5 pattern, core_done 20 cycles after core_start, core_result=7 -> core_start one pulse, result_out=7, result_valid=1 next cycle, lat_cycles=20 (PERF_EN).
REQ-041 core_done never asserted, TIMEOUT_CYC=16 -> err=1 after 16 RUN cycles, result_valid=0; result_clear -> IDLE, img_ready=1.
REQ-042 core_result=12 with NUM_CLASSES=10 -> ERR, err=1, result_valid=0.
REQ-043 core_done on watchdog terminal cycle with result=3 -> DONE, result_out=3, err=0.
REQ-044 img_valid held high during RUN and DONE -> no recapture; core_img unchanged; second image accepted only after result_clear.
REQ-045 rst_n low mid-RUN, then stray core_done -> IDLE, all outputs at reset values, result_valid stays 0.

Source files
------------

// File: rtl/bnn_pkg.sv
// Shared types and default geometry for the BNN inference controller.
package bnn_pkg;

    localparam int unsigned BNN_IMG_W       = 30;
    localparam int unsigned BNN_IMG_H       = 30;
    localparam int unsigned BNN_RESULT_W    = 4;
    localparam int unsigned BNN_NUM_CLASSES = 10;

    typedef enum logic [2:0] {
        IDLE,
        START,
        RUN,
        DONE,
        ERR
    } bnn_ctrl_state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/bnn_watchdog.sv
// RUN-phase watchdog: counts enabled cycles and flags the terminal count
// (TIMEOUT_CYC-1) combinationally so the controller can leave on that cycle.
module bnn_watchdog #(
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned WD_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WD_W-1:0] TERM = WD_W'(TIMEOUT_CYC - 1);

    logic [WD_W-1:0] count;

    // Cycle counter, zeroed while clear is high, parked at the terminal value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != TERM)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = enable && (count == TERM);

endmodule

// File: rtl/bnn_infer_ctrl.sv
// BNN inference controller: accepts an image, starts the core, waits for a
// class result under a watchdog and holds the result/error until cleared.
// Optional macro BNN_INFER_PERF_EN adds a core-latency counter on lat_cycles.
module bnn_infer_ctrl
    import bnn_pkg::*;
#(
    parameter int unsigned IMG_W       = BNN_IMG_W,
    parameter int unsigned IMG_H       = BNN_IMG_H,
    parameter int unsigned PAD_BITS    = 4,
    parameter int unsigned RESULT_W    = BNN_RESULT_W,
    parameter int unsigned NUM_CLASSES = BNN_NUM_CLASSES,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [IMG_W*IMG_H+PAD_BITS-1:0] img_in,
    input  logic                          img_valid,
    output logic                          img_ready,
    output logic [IMG_W*IMG_H-1:0]        core_img,
    output logic                          core_start,
    input  logic                          core_done,
    input  logic [RESULT_W-1:0]           core_result,
    output logic [RESULT_W-1:0]           result_out,
    output logic                          result_valid,
    input  logic                          result_clear,
    output logic                          err,
    output logic                          busy,
    output logic [15:0]                   lat_cycles
);

    localparam int unsigned PIX_W = IMG_W * IMG_H;
    localparam int unsigned IN_W  = PIX_W + PAD_BITS;

    bnn_ctrl_state_t state_q, state_d;
    logic            wd_expired;
    logic            in_range;

    generate
        if (PAD_BITS > 0) begin : g_pad
            logic unused_pad;
            assign unused_pad = ^img_in[PAD_BITS-1:0];
        end
    endgenerate

    assign in_range = (32'(core_result) < NUM_CLASSES);

    bnn_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state_q != RUN),
        .enable  (state_q == RUN),
        .expired (wd_expired)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and state-derived outputs.
    always_comb begin
        state_d      = state_q;
        img_ready    = 1'b0;
        core_start   = 1'b0;
        result_valid = 1'b0;
        err          = 1'b0;
        busy         = 1'b1;
        unique case (state_q)
            IDLE: begin
                img_ready = 1'b1;
                busy      = 1'b0;
                if (img_valid) state_d = START;
            end
            START: begin
                core_start = 1'b1;
                state_d    = RUN;
            end
            RUN: begin
                // core_done outranks the watchdog on its terminal cycle.
                if (core_done) begin
                    state_d = in_range ? DONE : ERR;
                end else if (wd_expired) begin
                    state_d = ERR;
                end
            end
            DONE: begin
                result_valid = 1'b1;
                if (result_clear) state_d = IDLE;
            end
            ERR: begin
                err = 1'b1;
                if (result_clear) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Image latch on acceptance and result capture on core_done in RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_img   <= '0;
            result_out <= '0;
        end else begin
            if ((state_q == IDLE) && img_valid) core_img <= img_in[IN_W-1:PAD_BITS];
            if ((state_q == RUN) && core_done) result_out <= core_result;
        end
    end

`ifdef BNN_INFER_PERF_EN
    logic [15:0] run_cnt;

    // RUN-cycle counter; the cycle carrying core_done is included in the total.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt    <= '0;
            lat_cycles <= '0;
        end else begin
            if (state_q == START) begin
                run_cnt <= '0;
            end else if (state_q == RUN) begin
                run_cnt <= sat_inc16(run_cnt);
            end
            if ((state_q == RUN) && core_done) lat_cycles <= sat_inc16(run_cnt);
        end
    end
`else
    assign lat_cycles = '0;
`endif

endmodule

// File: tb/tb_bnn_infer_ctrl.sv
// Scoreboard bench for bnn_infer_ctrl: expectations are queued when an image
// is accepted and popped when the controller reaches DONE or ERR.
module tb_bnn_infer_ctrl;

    localparam int unsigned IMG_W = 30;
    localparam int unsigned IMG_H = 30;
    localparam int unsigned PAD   = 4;
    localparam int unsigned RW    = 4;
    localparam int unsigned NC    = 10;
    localparam int unsigned TO    = 16;
    localparam int unsigned PIX   = IMG_W * IMG_H;
    localparam int unsigned IN_W  = PIX + PAD;
`ifdef BNN_INFER_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct {
        logic [RW-1:0] res;
        logic          err;
        logic [15:0]   lat;
        int            cyc;
    } exp_t;

    exp_t sb[$];
    int unsigned n_err = 0;
    int unsigned n_chk = 0;
    logic [15:0] last_lat = '0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [IN_W-1:0] img_in = '0;
    logic            img_valid = 1'b0, core_done = 1'b0, result_clear = 1'b0;
    logic [RW-1:0]   core_result = '0;
    logic            img_ready, core_start, result_valid, err, busy;
    logic [PIX-1:0]  core_img;
    logic [RW-1:0]   result_out;
    logic [15:0]     lat_cycles;

    logic [IN_W-1:0] lt_img_in = '0;
    logic            lt_img_valid = 1'b0, lt_core_done = 1'b0, lt_result_clear = 1'b0;
    logic [RW-1:0]   lt_core_result = '0;
    logic            lt_img_ready, lt_core_start, lt_result_valid, lt_err, lt_busy;
    logic [PIX-1:0]  lt_core_img;
    logic [RW-1:0]   lt_result_out;
    logic [15:0]     lt_lat_cycles;

    bnn_infer_ctrl #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .PAD_BITS(PAD), .RESULT_W(RW),
        .NUM_CLASSES(NC), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .img_in(img_in), .img_valid(img_valid),
        .img_ready(img_ready), .core_img(core_img), .core_start(core_start),
        .core_done(core_done), .core_result(core_result), .result_out(result_out),
        .result_valid(result_valid), .result_clear(result_clear), .err(err),
        .busy(busy), .lat_cycles(lat_cycles)
    );

    // Second instance with a long watchdog for the 20-cycle latency case.
    bnn_infer_ctrl #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .PAD_BITS(PAD), .RESULT_W(RW),
        .NUM_CLASSES(NC), .TIMEOUT_CYC(64)
    ) dut_lt (
        .clk(clk), .rst_n(rst_n), .img_in(lt_img_in), .img_valid(lt_img_valid),
        .img_ready(lt_img_ready), .core_img(lt_core_img), .core_start(lt_core_start),
        .core_done(lt_core_done), .core_result(lt_core_result), .result_out(lt_result_out),
        .result_valid(lt_result_valid), .result_clear(lt_result_clear), .err(lt_err),
        .busy(lt_busy), .lat_cycles(lt_lat_cycles)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [PIX-1:0] pattern(input logic [7:0] b);
        logic [1023:0] t;
        t = {128{b}};
        return t[PIX-1:0];
    endfunction

    function automatic logic [PIX-1:0] rand_img();
        logic [1023:0] t;
        for (int i = 0; i < 32; i++) t[i*32 +: 32] = $urandom;
        return t[PIX-1:0];
    endfunction

    task automatic check_reset_vals();
        check("rst_img_ready", 64'(img_ready), 64'(1));
        check("rst_core_start", 64'(core_start), 64'(0));
        check("rst_result_valid", 64'(result_valid), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_result_out", 64'(result_out), 64'(0));
        check("rst_core_img_zero", 64'(core_img == '0), 64'(1));
        check("rst_lat_cycles", 64'(lat_cycles), 64'(0));
    endtask

    // Present an image and confirm the START cycle.
    task automatic offer(input logic [PIX-1:0] pix, input logic keep_valid);
        int n = 0;
        while (!img_ready && n < 50) begin
            tick();
            n++;
        end
        check("ready_wait", 64'(img_ready), 64'(1));
        img_in    = {pix, 4'b1011};
        img_valid = 1'b1;
        tick();
        check("core_start", 64'(core_start), 64'(1));
        check("core_img_latch", 64'(core_img == pix), 64'(1));
        check("ready_low_start", 64'(img_ready), 64'(0));
        if (!keep_valid) img_valid = 1'b0;
    endtask

    // Play the core: core_done during RUN cycle d (0 = never), then score.
    task automatic run_core(input int d, input logic [RW-1:0] r,
                            input logic [PIX-1:0] pix, output exp_t eo);
        exp_t e;
        int   k;
        bit   fin;
        fin   = (d > 0) && (d <= int'(TO));
        e.err = !fin || (int'(r) >= int'(NC));
        e.res = r;
        e.lat = PERF ? (fin ? 16'(d) : last_lat) : 16'h0;
        e.cyc = fin ? d + 1 : int'(TO) + 1;
        sb.push_back(e);
        tick();
        check("start_one_pulse", 64'(core_start), 64'(0));
        k = 1;
        while (!result_valid && !err && k < 48) begin
            core_done    = (k == d);
            core_result  = (k == d) ? r : RW'(k);
            result_clear = (k == 2);
            check("img_hold_run", 64'(core_img == pix), 64'(1));
            tick();
            k++;
        end
        core_done    = 1'b0;
        result_clear = 1'b0;
        e = sb.pop_front();
        check("cycles_to_result", 64'(k), 64'(e.cyc));
        check("result_valid", 64'(result_valid), 64'(!e.err));
        check("err", 64'(err), 64'(e.err));
        if (!e.err) check("result_out", 64'(result_out), 64'(e.res));
        check("lat_cycles", 64'(lat_cycles), 64'(e.lat));
        if (fin) last_lat = e.lat;
        eo = e;
    endtask

    // Hold in DONE/ERR for a few cycles, then clear back to IDLE.
    task automatic finish_case(input logic [PIX-1:0] pix, input exp_t e);
        repeat (3) begin
            core_done = 1'b1;
            tick();
            check("hold_valid", 64'(result_valid), 64'(!e.err));
            check("hold_err", 64'(err), 64'(e.err));
            check("hold_img", 64'(core_img == pix), 64'(1));
            check("hold_ready", 64'(img_ready), 64'(0));
        end
        core_done    = 1'b0;
        result_clear = 1'b1;
        tick();
        result_clear = 1'b0;
        check("clr_ready", 64'(img_ready), 64'(1));
        check("clr_err", 64'(err), 64'(0));
        check("clr_valid", 64'(result_valid), 64'(0));
        check("clr_busy", 64'(busy), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL sim_time_limit: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [PIX-1:0] a5, ia, ib, ic;
        exp_t e;
        int k;
        a5 = pattern(8'hA5);

        #12;
        check_reset_vals();
        rst_n = 1'b1;
        tick();

        // Stray controls in IDLE are ignored.
        core_done = 1'b1; result_clear = 1'b1; core_result = 4'd5;
        tick();
        core_done = 1'b0; result_clear = 1'b0;
        check("idle_stray_busy", 64'(busy), 64'(0));
        check("idle_stray_valid", 64'(result_valid), 64'(0));

        // 20-cycle core latency on the long-watchdog instance.
        lt_img_in    = {a5, 4'h6};
        lt_img_valid = 1'b1;
        tick();
        lt_img_valid = 1'b0;
        check("lt_core_start", 64'(lt_core_start), 64'(1));
        check("lt_core_img", 64'(lt_core_img == a5), 64'(1));
        e.res = 4'd7; e.err = 1'b0; e.lat = PERF ? 16'd20 : 16'd0; e.cyc = 21;
        sb.push_back(e);
        tick();
        check("lt_start_one_pulse", 64'(lt_core_start), 64'(0));
        k = 1;
        while (!lt_result_valid && !lt_err && k < 48) begin
            lt_core_done   = (k == 20);
            lt_core_result = 4'd7;
            tick();
            k++;
        end
        lt_core_done = 1'b0;
        e = sb.pop_front();
        check("lt_cycles_to_result", 64'(k), 64'(e.cyc));
        check("lt_result_valid", 64'(lt_result_valid), 64'(1));
        check("lt_result_out", 64'(lt_result_out), 64'(e.res));
        check("lt_lat_cycles", 64'(lt_lat_cycles), 64'(e.lat));
        lt_result_clear = 1'b1;
        tick();
        lt_result_clear = 1'b0;
        check("lt_clr_ready", 64'(lt_img_ready), 64'(1));

        // Normal inference, A5 pixels.
        offer(a5, 1'b0);  run_core(10, 4'd7, a5, e);  finish_case(a5, e);
        // Watchdog timeout.
        ia = rand_img();
        offer(ia, 1'b0);  run_core(0, 4'd0, ia, e);   finish_case(ia, e);
        // Out-of-range class.
        offer(ia, 1'b0);  run_core(5, 4'd12, ia, e);  finish_case(ia, e);
        // core_done on the watchdog terminal cycle wins.
        offer(a5, 1'b0);  run_core(16, 4'd3, a5, e);  finish_case(a5, e);
        // Class boundaries: highest legal, first illegal.
        offer(ia, 1'b0);  run_core(1, 4'd9, ia, e);   finish_case(ia, e);
        offer(ia, 1'b0);  run_core(3, 4'd10, ia, e);  finish_case(ia, e);

        // img_valid held through RUN/DONE with a changed image: no recapture.
        ia = pattern(8'h5A);
        ib = rand_img();
        offer(ia, 1'b1);
        img_in = {ib, 4'b0110};
        run_core(6, 4'd2, ia, e);
        finish_case(ia, e);
        offer(ib, 1'b0);
        run_core(4, 4'd8, ib, e);
        finish_case(ib, e);

        // Reset mid-RUN, then a stray core_done.
        ic = rand_img();
        offer(ic, 1'b0);
        tick(); tick(); tick();
        check("pre_reset_busy", 64'(busy), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        check_reset_vals();
        last_lat = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        core_done   = 1'b1;
        core_result = 4'd4;
        tick();
        core_done = 1'b0;
        tick();
        check("post_rst_busy", 64'(busy), 64'(0));
        check("post_rst_valid", 64'(result_valid), 64'(0));
        check("post_rst_ready", 64'(img_ready), 64'(1));
        check("post_rst_result_out", 64'(result_out), 64'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
